dmem_arbiter: RTL
=================

# dmem_arbiter

Two-port round-robin arbiter that shares the single-port word-addressed data memory between requester 0 (core load/store unit) and requester 1 (debug/DMA loader). It sits between the requesters and the data memory's address, write-data, write-enable and combinational read-data pins. It serialises accesses through a small FSM and returns read data one cycle after grant with a valid pulse.

## Interface
- DATA_WIDTH, 32, data word width
- ADDRESS_WIDTH, 30, word address width on requester and memory ports
- MEMORY_SIZE, 16, log2 of memory depth in words
- clk_i  in  1  clock, all state on rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- req0_i / req1_i  in  1  access request, held with fields stable until grant
- addr0_i / addr1_i  in  ADDRESS_WIDTH  word address
- wdata0_i / wdata1_i  in  DATA_WIDTH  write data
- we0_i / we1_i  in  1  1 = write, 0 = read
- gnt0_o / gnt1_o  out  1  one-cycle pulse: access is being performed this cycle
- rvalid0_o / rvalid1_o  out  1  one-cycle pulse: response valid (reads and writes)
- rdata0_o / rdata1_o  out  DATA_WIDTH  read data, valid while rvalid
- err0_o / err1_o  out  1  out-of-range flag, valid while rvalid
- mem_address_o  out  ADDRESS_WIDTH  to memory address
- mem_writeData_o  out  DATA_WIDTH  to memory write data
- mem_writeEnable_o  out  1  to memory write enable
- mem_readData_i  in  DATA_WIDTH  from memory, combinational on mem_address_o

## Operation
- States: IDLE, ACCESS, RESP. Reset state IDLE.
- IDLE: if any req, choose winner, latch its addr/wdata/we and winner id into registers, go ACCESS; else stay.
- ACCESS: mem_address_o/mem_writeData_o driven from latched regs; mem_writeEnable_o = latched we; gnt of winner = 1; mem_readData_i captured into rdata register at end of cycle; go RESP.
- RESP: rvalid and rdata of winner driven from registers; loser's rvalid/rdata = 0. Arbitrate exactly as IDLE: if any req, latch and go ACCESS; else go IDLE.
- Arbitration: single request wins. Both requesting: requester != last winner wins. last-winner register resets to 1, so requester 0 wins the first tie. Updated on every latch.
- Requester protocol: hold req and fields until gnt seen; deassert (or present next request) the cycle after gnt. Write responses also pulse rvalid; rdata is the pre-write word.
- Outputs not owned by the current winner/state are 0.
- Reset values: all gnt/rvalid/err/rdata = 0, mem_writeEnable_o = 0, mem_address_o = 0, mem_writeData_o = 0.

## Timing
- Request sampled in cycle N (IDLE or RESP) -> gnt in N+1 -> rvalid/rdata in N+2.
- Sustained throughput: one access per 2 cycles; both requesters saturating alternate 0,1,0,1.
- mem_writeEnable_o is high only during ACCESS; memory commits at the ACCESS-ending edge.
- Reset asserted mid-ACCESS: mem_writeEnable_o drops immediately and no write commits. Reset in any state discards the in-flight request; no gnt/rvalid is issued for it.
- Request arriving during ACCESS is not sampled until RESP.

## Configuration
- DMEM_ARB_BOUNDS_CHECK_EN defined: latched address with any bit at or above MEMORY_SIZE set is out of range. mem_writeEnable_o is held 0 in ACCESS; gnt still pulses; RESP returns rdata = 0 and err = 1 for that requester.
- Undefined: no check; address passed through unchanged (memory truncates, aliasing wraps); err0_o/err1_o tied 0.

## Test plan
- Reset: rst_ni low with req0_i = 1 -> all outputs 0, no mem_writeEnable_o. Release -> gnt0 pulses 1 cycle later.
- Single write then read: req0 write addr 0x10 data 0xDEADBEEF, then read addr 0x10 -> gnt at N+1, rvalid at N+2, read rdata0_o = 0xDEADBEEF.
- Tie and round-robin: req0 and req1 held high from reset for 8 cycles -> grants 0,1,0,1 on alternate cycles; each rvalid 1 cycle after its gnt.
- Back-to-back: req1 reads 0x3, then 0x4 presented in its RESP cycle -> gnt1 at N+1, N+3; rvalid1 at N+2, N+4.
- Reset mid-ACCESS: req0 write 0x55 to addr 0x20, rst_ni low during ACCESS -> memory word 0x20 unchanged, no rvalid.
- Bounds (macro on): req1 write addr 0x10000 -> mem_writeEnable_o stays 0, rvalid1 with err1_o = 1, rdata1_o = 0; macro off -> writes word 0x0000, err1_o = 0.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter sharing a single-port word-addressed data memory.
// Define DMEM_ARB_BOUNDS_CHECK_EN to flag and suppress accesses beyond the memory depth.
module dmem_arbiter #(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDRESS_WIDTH = 30,
   parameter int unsigned MEMORY_SIZE   = 16
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     req0_i,
   input  logic [ADDRESS_WIDTH-1:0] addr0_i,
   input  logic [DATA_WIDTH-1:0]    wdata0_i,
   input  logic                     we0_i,
   input  logic                     req1_i,
   input  logic [ADDRESS_WIDTH-1:0] addr1_i,
   input  logic [DATA_WIDTH-1:0]    wdata1_i,
   input  logic                     we1_i,
   output logic                     gnt0_o,
   output logic                     gnt1_o,
   output logic                     rvalid0_o,
   output logic                     rvalid1_o,
   output logic [DATA_WIDTH-1:0]    rdata0_o,
   output logic [DATA_WIDTH-1:0]    rdata1_o,
   output logic                     err0_o,
   output logic                     err1_o,
   output logic [ADDRESS_WIDTH-1:0] mem_address_o,
   output logic [DATA_WIDTH-1:0]    mem_writeData_o,
   output logic                     mem_writeEnable_o,
   input  logic [DATA_WIDTH-1:0]    mem_readData_i
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_e;

   state_e state_q, state_d;
   logic   win_q, win_d;   // last winner, which is also the owner of the access in flight
   logic   oor_q, oor_d;

   logic                     req_any_c;
   logic                     pick1_c;
   logic                     launch_c;
   logic                     sel_we_c;
   logic                     sel_oor_c;
   logic [ADDRESS_WIDTH-1:0] sel_addr_c;
   logic [DATA_WIDTH-1:0]    sel_wdata_c;

   logic                     gnt0_q, gnt0_d;
   logic                     gnt1_q, gnt1_d;
   logic                     rvalid0_q, rvalid0_d;
   logic                     rvalid1_q, rvalid1_d;
   logic [DATA_WIDTH-1:0]    rdata0_q, rdata0_d;
   logic [DATA_WIDTH-1:0]    rdata1_q, rdata1_d;
   logic [ADDRESS_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
   logic                     mem_we_q, mem_we_d;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
   logic                     err0_q, err0_d;
   logic                     err1_q, err1_d;
`endif

   // Round-robin pick: a lone request wins; on a tie the requester that did not win last goes.
   assign req_any_c   = req0_i | req1_i;
   assign pick1_c     = req1_i & (~req0_i | ~win_q);
   assign launch_c    = req_any_c & ((state_q == ST_IDLE) | (state_q == ST_RESP));
   assign sel_addr_c  = pick1_c ? addr1_i  : addr0_i;
   assign sel_wdata_c = pick1_c ? wdata1_i : wdata0_i;
   assign sel_we_c    = pick1_c ? we1_i    : we0_i;

`ifdef DMEM_ARB_BOUNDS_CHECK_EN
   assign sel_oor_c = (sel_addr_c >> MEMORY_SIZE) != '0;
`else
   assign sel_oor_c = 1'b0;
`endif

   // State register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= ST_IDLE;
         win_q   <= 1'b1;
         oor_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         win_q   <= win_d;
         oor_q   <= oor_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      win_d   = win_q;
      oor_d   = oor_q;
      case (state_q)
         ST_IDLE, ST_RESP: begin
            state_d = ST_IDLE;
            if (launch_c) begin
               state_d = ST_ACCESS;
               win_d   = pick1_c;
               oor_d   = sel_oor_c;
            end
         end
         ST_ACCESS: state_d = ST_RESP;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Output logic: next values of the output registers
   always_comb begin
      logic [DATA_WIDTH-1:0] resp_data;
      resp_data   = '0;
      gnt0_d      = 1'b0;
      gnt1_d      = 1'b0;
      rvalid0_d   = 1'b0;
      rvalid1_d   = 1'b0;
      rdata0_d    = '0;
      rdata1_d    = '0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      mem_we_d    = 1'b0;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
      err0_d      = 1'b0;
      err1_d      = 1'b0;
`endif
      if (launch_c) begin
         gnt0_d      = ~pick1_c;
         gnt1_d      = pick1_c;
         mem_addr_d  = sel_addr_c;
         mem_wdata_d = sel_wdata_c;
         mem_we_d    = sel_we_c & ~sel_oor_c;
      end
      if (state_q == ST_ACCESS) begin
         resp_data = oor_q ? '0 : mem_readData_i;
         if (win_q) begin
            rvalid1_d = 1'b1;
            rdata1_d  = resp_data;
         end else begin
            rvalid0_d = 1'b1;
            rdata0_d  = resp_data;
         end
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
         err0_d = ~win_q & oor_q;
         err1_d = win_q & oor_q;
`endif
      end
   end

   // Output registers; async reset drops the write enable mid-access
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         rvalid0_q   <= 1'b0;
         rvalid1_q   <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_we_q    <= 1'b0;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
         err0_q      <= 1'b0;
         err1_q      <= 1'b0;
`endif
      end else begin
         gnt0_q      <= gnt0_d;
         gnt1_q      <= gnt1_d;
         rvalid0_q   <= rvalid0_d;
         rvalid1_q   <= rvalid1_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_we_q    <= mem_we_d;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
         err0_q      <= err0_d;
         err1_q      <= err1_d;
`endif
      end
   end

   assign gnt0_o            = gnt0_q;
   assign gnt1_o            = gnt1_q;
   assign rvalid0_o         = rvalid0_q;
   assign rvalid1_o         = rvalid1_q;
   assign rdata0_o          = rdata0_q;
   assign rdata1_o          = rdata1_q;
   assign mem_address_o     = mem_addr_q;
   assign mem_writeData_o   = mem_wdata_q;
   assign mem_writeEnable_o = mem_we_q;
`ifdef DMEM_ARB_BOUNDS_CHECK_EN
   assign err0_o = err0_q;
   assign err1_o = err1_q;
`else
   assign err0_o = 1'b0;
   assign err1_o = 1'b0;
`endif

endmodule
